// File: rtl/line_fill_ram_if.sv
// Request/response bus between the data-cache controller (master) and the
// line-fill RAM responder (slave).
interface line_fill_ram_if;
  logic         ireq_valid;
  logic         ireq_write;
  logic [31:0]  iaddr;
  logic [31:0]  iwdata;
  logic         oready;
  logic         oresp_valid;
  logic [127:0] oline_data;
  logic         oerr;

  modport master (
    output ireq_valid, ireq_write, iaddr, iwdata,
    input  oready, oresp_valid, oline_data, oerr
  );

  modport slave (
    input  ireq_valid, ireq_write, iaddr, iwdata,
    output oready, oresp_valid, oline_data, oerr
  );
endinterface

// File: rtl/line_fill_ram.sv
// Main-memory responder: 128-bit line fills and 32-bit write-through, fixed latency.
// Optional macro RAM_OOR_CHECK_EN: flag out-of-range accesses via oerr instead of wrapping.
module line_fill_ram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 4
) (
  input  logic            clk,
  input  logic            rst,
  line_fill_ram_if.slave  bus
);

  localparam int unsigned AW     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("line_fill_ram: LATENCY must be in 1..15");
  end
  if (DEPTH_WORDS < 4 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $error("line_fill_ram: DEPTH_WORDS must be a power of two >= 4");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t         r_state, w_next;
  logic [3:0]     r_cnt;
  logic [AW-1:0]  r_widx, w_widx;
  logic [31:0]    r_wdata, w_wdata;
  logic           r_write, w_write;
  logic           r_oor, w_oor;
  logic           w_accept, w_enter_resp;
  logic [127:0]   r_line;
  logic [31:0]    r_mem [DEPTH_WORDS];
  logic           w_unused;

  assign w_accept = (r_state == S_IDLE) && bus.ireq_valid;

  // With LATENCY==1 the access happens on the accept edge, before the request
  // registers hold it, so the live inputs are used while still in IDLE.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_widx  = bus.iaddr[AW+1:2];
      w_wdata = bus.iwdata;
      w_write = bus.ireq_write;
      w_oor   = |bus.iaddr[31:AW+2];
    end else begin
      w_widx  = r_widx;
      w_wdata = r_wdata;
      w_write = r_write;
      w_oor   = r_oor;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.ireq_valid) w_next = (LATENCY == 1) ? S_RESP : S_WAIT;
      S_WAIT: if (r_cnt == 4'd1) w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_enter_resp = (r_state != S_RESP) && (w_next == S_RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_widx  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
      r_oor   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt   <= LAT_M1;
        r_widx  <= bus.iaddr[AW+1:2];
        r_wdata <= bus.iwdata;
        r_write <= bus.ireq_write;
        r_oor   <= |bus.iaddr[31:AW+2];
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

`ifdef RAM_OOR_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_line <= '0;
    end else if (w_enter_resp && !w_write) begin
      r_line <= w_oor ? '0 :
                {r_mem[{w_widx[AW-1:2], 2'd3}], r_mem[{w_widx[AW-1:2], 2'd2}],
                 r_mem[{w_widx[AW-1:2], 2'd1}], r_mem[{w_widx[AW-1:2], 2'd0}]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_enter_resp && w_write && !w_oor) r_mem[w_widx] <= w_wdata;
  end

  assign bus.oerr = (r_state == S_RESP) && r_oor;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      r_line <= '0;
    end else if (w_enter_resp && !w_write) begin
      r_line <= {r_mem[{w_widx[AW-1:2], 2'd3}], r_mem[{w_widx[AW-1:2], 2'd2}],
                 r_mem[{w_widx[AW-1:2], 2'd1}], r_mem[{w_widx[AW-1:2], 2'd0}]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_enter_resp && w_write) r_mem[w_widx] <= w_wdata;
  end

  assign bus.oerr = 1'b0;
`endif

  assign bus.oready      = (r_state == S_IDLE);
  assign bus.oresp_valid = (r_state == S_RESP);
  assign bus.oline_data  = r_line;

  assign w_unused = ^{bus.iaddr[1:0], w_oor, r_oor};

endmodule

// File: tb/tb_line_fill_ram.sv
// Directed self-checking bench for line_fill_ram: one instance at LATENCY=4
// and one at LATENCY=1, both with DEPTH_WORDS=1024.
module tb_line_fill_ram;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  line_fill_ram_if bus4 ();
  line_fill_ram_if bus1 ();

  line_fill_ram #(.DEPTH_WORDS(1024), .LATENCY(4)) u_dut4 (
    .clk(clk), .rst(rst), .bus(bus4)
  );
  line_fill_ram #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One LATENCY=4 transaction; poke drives a competing write while busy.
  task automatic req4(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input bit poke, input string tag, output logic [127:0] line,
                      output logic err);
    chk1({tag, ":ready_before"}, bus4.oready, 1'b1);
    bus4.ireq_valid = 1'b1;
    bus4.ireq_write = wr;
    bus4.iaddr      = a;
    bus4.iwdata     = d;
    tick();
    for (int unsigned k = 1; k < 4; k++) begin
      if (poke) begin
        bus4.ireq_valid = 1'b1;
        bus4.ireq_write = 1'b1;
        bus4.iaddr      = 32'h0;
        bus4.iwdata     = 32'h1;
      end else begin
        bus4.ireq_valid = 1'b0;
        bus4.ireq_write = 1'($urandom);
        bus4.iaddr      = $urandom;
        bus4.iwdata     = $urandom;
      end
      chk1({tag, ":no_resp_early"}, bus4.oresp_valid, 1'b0);
      chk1({tag, ":busy"}, bus4.oready, 1'b0);
      tick();
    end
    bus4.ireq_valid = 1'b0;
    chk1({tag, ":resp_at_T+4"}, bus4.oresp_valid, 1'b1);
    chk1({tag, ":not_ready_in_resp"}, bus4.oready, 1'b0);
    line = bus4.oline_data;
    err  = bus4.oerr;
    tick();
    chk1({tag, ":resp_one_cycle"}, bus4.oresp_valid, 1'b0);
    chk1({tag, ":ready_after"}, bus4.oready, 1'b1);
  endtask

  task automatic req1(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input string tag, output logic [127:0] line);
    chk1({tag, ":ready_before"}, bus1.oready, 1'b1);
    bus1.ireq_valid = 1'b1;
    bus1.ireq_write = wr;
    bus1.iaddr      = a;
    bus1.iwdata     = d;
    tick();
    bus1.ireq_valid = 1'b0;
    bus1.iaddr      = $urandom;
    chk1({tag, ":resp_at_T+1"}, bus1.oresp_valid, 1'b1);
    chk1({tag, ":not_ready_in_resp"}, bus1.oready, 1'b0);
    line = bus1.oline_data;
    tick();
    chk1({tag, ":resp_one_cycle"}, bus1.oresp_valid, 1'b0);
    chk1({tag, ":ready_at_T+2"}, bus1.oready, 1'b1);
  endtask

  initial begin
    logic [127:0] line;
    logic         err;

    bus4.ireq_valid = 1'b0; bus4.ireq_write = 1'b0; bus4.iaddr = '0; bus4.iwdata = '0;
    bus1.ireq_valid = 1'b0; bus1.ireq_write = 1'b0; bus1.iaddr = '0; bus1.iwdata = '0;

    // Reset held two cycles
    rst = 1'b1;
    tick();
    tick();
    chk1("reset:oready", bus4.oready, 1'b1);
    chk1("reset:oresp_valid", bus4.oresp_valid, 1'b0);
    chk128("reset:oline_data", bus4.oline_data, '0);
    chk1("reset:oerr", bus4.oerr, 1'b0);
    chk1("reset1:oready", bus1.oready, 1'b1);
    chk128("reset1:oline_data", bus1.oline_data, '0);
    rst = 1'b0;
    tick();

    // Preload word 0, then write 0xDEADBEEF @0x24 and read line @0x20
    req4(1'b1, 32'h0, 32'h1234_5678, 1'b0, "wr_preload", line, err);
    chk128("wr_preload:line_unchanged", bus4.oline_data, '0);
    req4(1'b1, 32'h24, 32'hDEAD_BEEF, 1'b0, "wr_24", line, err);
    req4(1'b0, 32'h20, 32'h0, 1'b0, "rd_20", line, err);
    chk32("rd_20:word1", line[63:32], 32'hDEAD_BEEF);

    // Full line word ordering, read with a mid-line address
    for (int unsigned k = 0; k < 4; k++)
      req4(1'b1, 32'h30 + 32'(4 * k), 32'hA000_0000 + 32'(k), 1'b0, "wr_line30", line, err);
    req4(1'b0, 32'h34, 32'h0, 1'b0, "rd_34", line, err);
    chk128("rd_34:line", line, {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000});
    chk32("rd_34:hold", bus4.oline_data[127:96], 32'hA000_0003);

    // Write leaves the previous read line in place
    req4(1'b1, 32'h38, 32'h5A5A_5A5A, 1'b0, "wr_38", line, err);
    chk128("wr_38:line_held", bus4.oline_data,
           {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000});
    req4(1'b0, 32'h30, 32'h0, 1'b0, "rd_30", line, err);
    chk32("rd_30:word2", line[95:64], 32'h5A5A_5A5A);

    // LATENCY=1 instance
    req1(1'b1, 32'h8, 32'h0BAD_F00D, "l1_wr_8", line);
    req1(1'b0, 32'h0, 32'h0, "l1_rd_0", line);
    chk32("l1_rd_0:word2", line[95:64], 32'h0BAD_F00D);

    // Busy drop: write 0x1 @0x0 offered while busy must be ignored
    req4(1'b0, 32'h20, 32'h0, 1'b1, "busy_rd", line, err);
    tick();
    chk1("busy:no_late_accept", bus4.oready, 1'b1);
    req4(1'b0, 32'h0, 32'h0, 1'b0, "busy_check", line, err);
    chk32("busy_check:word0", line[31:0], 32'h1234_5678);

    // Reset mid-operation discards a pending write
    req4(1'b1, 32'h40, 32'hCAFE_F00D, 1'b0, "wr_40_old", line, err);
    chk1("rst_mid:ready_before", bus4.oready, 1'b1);
    bus4.ireq_valid = 1'b1;
    bus4.ireq_write = 1'b1;
    bus4.iaddr      = 32'h40;
    bus4.iwdata     = 32'h55;
    tick();
    bus4.ireq_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk1("rst_mid:idle", bus4.oready, 1'b1);
    chk1("rst_mid:no_resp", bus4.oresp_valid, 1'b0);
    chk128("rst_mid:line_cleared", bus4.oline_data, '0);
    rst = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      tick();
      chk1("rst_mid:no_resp_after", bus4.oresp_valid, 1'b0);
    end
    req4(1'b0, 32'h40, 32'h0, 1'b0, "rst_mid_rd", line, err);
    chk32("rst_mid_rd:word0", line[31:0], 32'hCAFE_F00D);

    // Out-of-range read @0x10000
    req4(1'b0, 32'h0001_0000, 32'h0, 1'b0, "oor_rd", line, err);
`ifdef RAM_OOR_CHECK_EN
    chk1("oor_rd:oerr", err, 1'b1);
    chk128("oor_rd:line_zero", line, '0);
`else
    chk1("oor_rd:oerr", err, 1'b0);
    chk32("oor_rd:wrap_word0", line[31:0], 32'h1234_5678);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
